// File: rtl/uart_mem_ctrl.sv
// UART-driven loader/dumper: 'L' streams bytes into imem, 'D' streams dmem out over tx, 'R' releases the CPU.
// Define UART_MEM_CTRL_CHECKSUM_EN to append an 8-bit sum of the loaded bytes after a completed load.
module uart_mem_ctrl #(
    parameter int IMEM_BYTE_ADDR_WIDTH = 6,
    parameter int DMEM_BYTE_ADDR_WIDTH = 6,
    parameter int WORD_BYTES           = 4,
    parameter int TIMEOUT_WIDTH        = 16,
    localparam int WB                  = $clog2(WORD_BYTES)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               rx_valid,
    input  logic [7:0]                         rx_data,
    output logic                               tx_req,
    output logic [7:0]                         tx_data,
    input  logic                               tx_busy,
    output logic                               cpu_rst,
    output logic                               imem_ctrl,
    output logic                               imem_wr_en,
    output logic [IMEM_BYTE_ADDR_WIDTH-WB-1:0] imem_addr,
    output logic [WORD_BYTES-1:0]              imem_byte_en,
    output logic [8*WORD_BYTES-1:0]            imem_wr_data,
    output logic                               dmem_ctrl,
    output logic                               dmem_rd_en,
    output logic [DMEM_BYTE_ADDR_WIDTH-WB-1:0] dmem_addr,
    input  logic [8*WORD_BYTES-1:0]            dmem_rd_data
);

    localparam int IA = IMEM_BYTE_ADDR_WIDTH;
    localparam int DA = DMEM_BYTE_ADDR_WIDTH;
    localparam int AW = (IA > DA) ? IA : DA;
    localparam int LW = (WB > 0) ? WB : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DUMP_RD,
        DUMP_CAP,
        DUMP_TX,
        DUMP_WAIT
`ifdef UART_MEM_CTRL_CHECKSUM_EN
        , CKSUM_TX
`endif
    } state_e;

    state_e                   state_q;
    logic [AW-1:0]            addr_q;
    logic [TIMEOUT_WIDTH-1:0] tmo_q;
    logic                     cpu_rst_q;
    logic                     tx_req_q;
    logic [7:0]               tx_data_q;
    logic                     skip_q;
`ifdef UART_MEM_CTRL_CHECKSUM_EN
    logic [7:0]               cksum_q;
`endif

    logic [LW-1:0] lane;
    logic [7:0]    rd_lane;
    logic          tmo_hit;
    logic          load_last;
    logic          dump_last;

    // A single-byte word has no lane bits, so the lane is tied to zero.
    if (WB > 0) begin : g_lane
        assign lane = addr_q[LW-1:0];
    end else begin : g_lane_none
        assign lane = '0;
    end

    assign rd_lane   = dmem_rd_data[8*lane +: 8];
    assign tmo_hit   = &tmo_q;
    assign load_last = &addr_q[IA-1:0];
    assign dump_last = &addr_q[DA-1:0];

    assign cpu_rst      = cpu_rst_q;
    assign tx_req       = tx_req_q;
    assign tx_data      = tx_data_q;
    assign imem_ctrl    = (state_q == LOAD);
    assign imem_wr_en   = (state_q == LOAD) && rx_valid && !tmo_hit;
    assign imem_addr    = addr_q[IA-1:WB];
    assign imem_byte_en = WORD_BYTES'(1) << lane;
    assign imem_wr_data = {WORD_BYTES{rx_data}};
    assign dmem_ctrl    = (state_q == DUMP_RD) || (state_q == DUMP_CAP) ||
                          (state_q == DUMP_TX) || (state_q == DUMP_WAIT);
    assign dmem_rd_en   = (state_q == DUMP_RD);
    assign dmem_addr    = addr_q[DA-1:WB];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            tmo_q     <= '0;
            cpu_rst_q <= 1'b1;
            tx_req_q  <= 1'b0;
            tx_data_q <= 8'h00;
            skip_q    <= 1'b0;
`ifdef UART_MEM_CTRL_CHECKSUM_EN
            cksum_q   <= 8'h00;
`endif
        end else begin
            tx_req_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            8'h4C: begin
                                state_q   <= LOAD;
                                addr_q    <= '0;
                                tmo_q     <= '0;
                                cpu_rst_q <= 1'b1;
`ifdef UART_MEM_CTRL_CHECKSUM_EN
                                cksum_q   <= 8'h00;
`endif
                            end
                            8'h44: begin
                                state_q   <= DUMP_RD;
                                addr_q    <= '0;
                                cpu_rst_q <= 1'b1;
                            end
                            8'h52:   cpu_rst_q <= 1'b0;
                            default: ;
                        endcase
                    end
                end
                // Timeout wins over a coincident byte, so an aborted load never writes.
                LOAD: begin
                    if (tmo_hit) begin
                        state_q <= IDLE;
                        tmo_q   <= '0;
                    end else if (rx_valid) begin
                        tmo_q <= '0;
`ifdef UART_MEM_CTRL_CHECKSUM_EN
                        cksum_q <= cksum_q + rx_data;
`endif
                        if (load_last) begin
                            addr_q <= '0;
`ifdef UART_MEM_CTRL_CHECKSUM_EN
                            state_q <= CKSUM_TX;
`else
                            state_q <= IDLE;
`endif
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                DUMP_RD: state_q <= DUMP_CAP;
                DUMP_CAP: begin
                    tx_data_q <= rd_lane;
                    state_q   <= DUMP_TX;
                end
                DUMP_TX: begin
                    if (!tx_busy) begin
                        tx_req_q <= 1'b1;
                        skip_q   <= 1'b1;
                        state_q  <= DUMP_WAIT;
                    end
                end
                // The first wait cycle is skipped because busy only rises after the request is seen.
                DUMP_WAIT: begin
                    if (skip_q) begin
                        skip_q <= 1'b0;
                    end else if (!tx_busy) begin
                        if (dump_last) begin
                            addr_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            addr_q  <= addr_q + 1'b1;
                            state_q <= DUMP_RD;
                        end
                    end
                end
`ifdef UART_MEM_CTRL_CHECKSUM_EN
                CKSUM_TX: begin
                    if (!tx_busy) begin
                        tx_data_q <= cksum_q;
                        tx_req_q  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
